// File: rtl/uart_tx_ctrl_param.sv
// UART transmit controller: latches a word plus frame config on accept and
// serialises start, DATA_WIDTH data bits (LSB first), optional parity, 1-2 stops.
module uart_tx_ctrl_param #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Data_Valid,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  Stop_Sel,
   output logic                  Data_Accepted,
   output logic                  TX_OUT,
   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   state_t                  state;
   state_t                  next_state;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    par_en_q;
   logic                    par_typ_q;
   logic                    stop_sel_q;
   logic [CNT_W-1:0]        cnt;
   logic                    last_stop;

   // Even parity is the XOR of the word; odd parity is its complement.
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         stop_sel_q <= 1'b0;
         cnt        <= '0;
      end else if (Data_Accepted) begin
         data_q     <= P_DATA;
         par_en_q   <= PAR_EN;
         par_typ_q  <= PAR_TYP;
         stop_sel_q <= Stop_Sel;
         cnt        <= '0;
      end else if (state == DATA) begin
         cnt <= (cnt == LAST_BIT) ? '0 : cnt + 1'b1;
      end
   end

   // A new word may only be taken when the line is free or in the final stop bit,
   // which gives gap-free back-to-back frames.
   always_comb begin
      last_stop     = ((state == STOP1) && !stop_sel_q) || ((state == STOP2) && stop_sel_q);
      Data_Accepted = Data_Valid && ((state == IDLE) || last_stop);
      next_state    = IDLE;
      TX_OUT        = 1'b1;
      busy          = (state != IDLE);
      case (state)
         IDLE:    next_state = Data_Accepted ? START : IDLE;
         START: begin
            TX_OUT     = 1'b0;
            next_state = DATA;
         end
         DATA: begin
            TX_OUT = data_q[cnt];
            if (cnt == LAST_BIT) begin
               next_state = par_en_q ? PARITY : STOP1;
            end else begin
               next_state = DATA;
            end
         end
         PARITY: begin
            TX_OUT     = parity_bit(data_q, par_typ_q);
            next_state = STOP1;
         end
         STOP1: begin
            if (stop_sel_q) begin
               next_state = STOP2;
            end else begin
               next_state = Data_Accepted ? START : IDLE;
            end
         end
         STOP2:   next_state = Data_Accepted ? START : IDLE;
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl_param.sv
// Scoreboard bench for uart_tx_ctrl_param: an 8-bit and a 5-bit instance, each with
// a frame-level reference model feeding an expected-bit queue and a line monitor.
module tb_uart_tx_ctrl_param;

   typedef bit bitq_t[$];

   logic       clk;
   logic       rst8, rst5;
   logic       dv8, pe8, pt8, ss8;
   logic [7:0] pd8;
   logic       acc8, tx8, busy8;
   logic       dv5, pe5, pt5, ss5;
   logic [4:0] pd5;
   logic       acc5, tx5, busy5;

   int  n_total = 0;
   int  n_pass  = 0;
   int  pulses8 = 0;
   int  pulses5 = 0;
   bit  q8[$];
   bit  q5[$];

   uart_tx_ctrl_param #(.DATA_WIDTH(8)) u8 (
      .clk(clk), .rst(rst8), .Data_Valid(dv8), .P_DATA(pd8), .PAR_EN(pe8),
      .PAR_TYP(pt8), .Stop_Sel(ss8), .Data_Accepted(acc8), .TX_OUT(tx8), .busy(busy8)
   );

   uart_tx_ctrl_param #(.DATA_WIDTH(5)) u5 (
      .clk(clk), .rst(rst5), .Data_Valid(dv5), .P_DATA(pd5), .PAR_EN(pe5),
      .PAR_TYP(pt5), .Stop_Sel(ss5), .Data_Accepted(acc5), .TX_OUT(tx5), .busy(busy5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference frame: start 0, data LSB first, parity making the total count of ones
   // even (or odd when odd parity is selected), then one or two stop 1s.
   function automatic bitq_t frame_bits(input int w, input logic [8:0] d,
                                        input bit pe, input bit pt, input bit ss);
      bitq_t b;
      int    ones = 0;
      b.push_back(1'b0);
      for (int i = 0; i < w; i++) begin
         b.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pe) b.push_back(((ones % 2) == 1) ^ pt);
      b.push_back(1'b1);
      if (ss) b.push_back(1'b1);
      return b;
   endfunction

   // Line monitors: while busy every cycle must match the next expected bit;
   // while idle the line must be high with nothing outstanding.
   always @(negedge clk) begin
      if (rst8) begin
         if (busy8) begin
            if (q8.size() == 0) check("u8_busy_without_frame", 1, 0);
            else check("u8_tx_bit", int'(tx8), int'(q8.pop_front()));
         end else begin
            check("u8_idle_tx", int'(tx8), 1);
            check("u8_idle_pending", q8.size(), 0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst5) begin
         if (busy5) begin
            if (q5.size() == 0) check("u5_busy_without_frame", 1, 0);
            else check("u5_tx_bit", int'(tx5), int'(q5.pop_front()));
         end else begin
            check("u5_idle_tx", int'(tx5), 1);
            check("u5_idle_pending", q5.size(), 0);
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (acc8) pulses8++;
      if (acc5) pulses5++;
   end

   // Called just after a falling edge; returns just after the falling edge that
   // follows the accepting rising edge, with Data_Valid already dropped.
   task automatic send8(input logic [7:0] d, input bit pe, input bit pt, input bit ss);
      bit    got = 0;
      bitq_t f;
      pd8 = d; pe8 = pe; pt8 = pt; ss8 = ss; dv8 = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         #1;
         if (acc8) begin
            got = 1;
            f = frame_bits(8, {1'b0, d}, pe, pt, ss);
            foreach (f[j]) q8.push_back(f[j]);
         end
         @(negedge clk);
      end
      dv8 = 1'b0;
      if (!got) check("u8_accept_timeout", 0, 1);
   endtask

   task automatic send5(input logic [4:0] d, input bit pe, input bit pt, input bit ss);
      bit    got = 0;
      bitq_t f;
      pd5 = d; pe5 = pe; pt5 = pt; ss5 = ss; dv5 = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         #1;
         if (acc5) begin
            got = 1;
            f = frame_bits(5, {4'b0, d}, pe, pt, ss);
            foreach (f[j]) q5.push_back(f[j]);
         end
         @(negedge clk);
      end
      dv5 = 1'b0;
      if (!got) check("u5_accept_timeout", 0, 1);
   endtask

   task automatic wait_idle8();
      int n = 0;
      while ((q8.size() != 0 || busy8) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("u8_frame_drained", int'(q8.size() == 0 && !busy8), 1);
   endtask

   task automatic wait_idle5();
      int n = 0;
      while ((q5.size() != 0 || busy5) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("u5_frame_drained", int'(q5.size() == 0 && !busy5), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0;
      rst8 = 1'b0; rst5 = 1'b0;
      dv8 = 0; pd8 = '0; pe8 = 0; pt8 = 0; ss8 = 0;
      dv5 = 0; pd5 = '0; pe5 = 0; pt5 = 0; ss5 = 0;

      // reset held three cycles, then a quiet idle stretch
      #1;
      check("rst_tx", int'(tx8), 1);
      check("rst_busy", int'(busy8), 0);
      check("rst_acc", int'(acc8), 0);
      repeat (3) @(negedge clk);
      rst8 = 1'b1; rst5 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         check("idle_acc", int'(acc8), 0);
         check("idle_busy", int'(busy8), 0);
      end
      @(negedge clk);

      // basic frame A5
      p0 = pulses8;
      send8(8'hA5, 0, 0, 0);
      wait_idle8();
      check("basic_accept_pulses", pulses8 - p0, 1);

      // parity with two stop bits, even then odd
      send8(8'h07, 1, 0, 1);
      wait_idle8();
      send8(8'h07, 1, 1, 1);
      wait_idle8();

      // back-to-back with Data_Valid held high
      p0 = pulses8;
      send8(8'h55, 0, 0, 0);
      send8(8'h0F, 0, 0, 0);
      wait_idle8();
      check("b2b_accept_pulses", pulses8 - p0, 2);

      // mid-frame interference during the DATA state
      p0 = pulses8;
      send8(8'h3C, 1, 1, 0);
      @(negedge clk);
      @(negedge clk);
      pd8 = 8'hC3; pe8 = 0; ss8 = 1; dv8 = 1'b1;
      #1;
      check("midframe_acc", int'(acc8), 0);
      @(negedge clk);
      pd8 = 8'hFF; pt8 = 0;
      #1;
      check("midframe_acc2", int'(acc8), 0);
      dv8 = 1'b0;
      wait_idle8();
      check("midframe_accept_pulses", pulses8 - p0, 1);

      // randomized frames with random gaps (zero gap gives back-to-back)
      for (int k = 0; k < 24; k++) begin
         send8(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle8();

      // 5-bit instance: reset during the 4th data bit
      send5(5'h1A, 0, 0, 0);
      repeat (4) @(negedge clk);
      #3;
      rst5 = 1'b0;
      #1;
      check("u5_rst_tx", int'(tx5), 1);
      check("u5_rst_busy", int'(busy5), 0);
      check("u5_rst_acc", int'(acc5), 0);
      q5.delete();
      @(negedge clk);
      #3;
      rst5 = 1'b1;
      repeat (3) @(negedge clk);
      p0 = pulses5;
      send5(5'h13, 1, 0, 0);
      wait_idle5();
      check("u5_accept_pulses", pulses5 - p0, 1);
      for (int k = 0; k < 10; k++) begin
         send5(5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle5();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
